// File: rtl/apb_to_axi_bridge_pkg.sv
// rtl/apb_to_axi_bridge_pkg.sv - shared AXI encodings and bridge FSM states
//
// Purpose: AXI size/burst/response constants used by the APB-to-AXI bridge,
//          the bridge state encoding, and a response-to-error helper.
// Ports:   none (package).
package apb_to_axi_bridge_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_ACK   = 3'd5
  } bridge_state_t;

  // SLVERR and DECERR both become PSLVERR; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/apb_to_axi_bridge.sv
// rtl/apb_to_axi_bridge.sv - APB3 completer to AXI3 single-beat manager bridge
//
// Purpose: turns each APB transfer into one 32-bit AXI transaction (AW+W then
//          B for writes, AR then R for reads). PREADY stays low until the AXI
//          response arrives; SLVERR/DECERR are reported as PSLVERR.
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request
//   PRDATA/PREADY/PSLVERR         APB completion (registered)
//   AW*/W*/AR*                    AXI request channels (registered)
//   B*/R*                         AXI response channels
module apb_to_axi_bridge
  import apb_to_axi_bridge_pkg::*;
#(
  parameter int WIDTH_CID = 4,
  parameter int WIDTH_ID  = 4,
  parameter int WIDTH_SID = WIDTH_CID + WIDTH_ID,
  parameter int WIDTH_AD  = 32,
  parameter int WIDTH_DA  = 32,
  parameter int AXI_ID    = 0
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [WIDTH_AD-1:0]  PADDR,
  input  logic [WIDTH_DA-1:0]  PWDATA,
  output logic [WIDTH_DA-1:0]  PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [WIDTH_SID-1:0] AWID,
  output logic [WIDTH_AD-1:0]  AWADDR,
  output logic [3:0]           AWLEN,
  output logic [2:0]           AWSIZE,
  output logic [1:0]           AWBURST,
  output logic [1:0]           AWLOCK,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [WIDTH_SID-1:0] WID,
  output logic [WIDTH_DA-1:0]  WDATA,
  output logic [3:0]           WSTRB,
  output logic                 WLAST,
  output logic                 WVALID,
  input  logic                 WREADY,
  input  logic [WIDTH_SID-1:0] BID,
  input  logic [1:0]           BRESP,
  input  logic                 BVALID,
  output logic                 BREADY,
  output logic [WIDTH_SID-1:0] ARID,
  output logic [WIDTH_AD-1:0]  ARADDR,
  output logic [3:0]           ARLEN,
  output logic [2:0]           ARSIZE,
  output logic [1:0]           ARBURST,
  output logic [1:0]           ARLOCK,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [WIDTH_SID-1:0] RID,
  input  logic [WIDTH_DA-1:0]  RDATA,
  input  logic [1:0]           RRESP,
  input  logic                 RLAST,
  input  logic                 RVALID,
  output logic                 RREADY
);

  bridge_state_t       state;
  logic [WIDTH_AD-1:0] addr_q;
  logic                aw_done;
  logic                w_done;

  // Handshakes taking place at the coming edge; a channel is finished once
  // it has either already handshaked or is handshaking now.
  logic aw_hs, w_hs, aw_fin, w_fin;
  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  // Fixed single-beat, full-word attributes.
  assign AWID    = WIDTH_SID'(AXI_ID);
  assign WID     = WIDTH_SID'(AXI_ID);
  assign ARID    = WIDTH_SID'(AXI_ID);
  assign AWLEN   = 4'd0;
  assign ARLEN   = 4'd0;
  assign AWSIZE  = AXI_SIZE_4B;
  assign ARSIZE  = AXI_SIZE_4B;
  assign AWBURST = AXI_BURST_INCR;
  assign ARBURST = AXI_BURST_INCR;
  assign AWLOCK  = 2'b00;
  assign ARLOCK  = 2'b00;
  assign WSTRB   = 4'hF;
  assign WLAST   = 1'b1;
  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;

  // Byte lane bits, IDs and RLAST carry no information for single-beat,
  // word-aligned traffic with one outstanding transaction.
  logic unused_inputs;
  assign unused_inputs = ^{PADDR[1:0], BID, RID, RLAST};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      WDATA   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      ARVALID <= 1'b0;
      BREADY  <= 1'b0;
      RREADY  <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Only a setup phase launches a transfer; the access phase that
          // follows is absorbed while the AXI side runs.
          if (PSEL && !PENABLE) begin
            addr_q  <= {PADDR[WIDTH_AD-1:2], 2'b00};
            WDATA   <= PWDATA;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (PWRITE) begin
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= ST_WADDR;
            end else begin
              ARVALID <= 1'b1;
              state   <= ST_RADDR;
            end
          end
        end
        ST_WADDR: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            BREADY <= 1'b1;
            state  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (BVALID) begin
            BREADY  <= 1'b0;
            PREADY  <= 1'b1;
            PSLVERR <= resp_is_err(BRESP);
            state   <= ST_ACK;
          end
        end
        ST_RADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (RVALID) begin
            RREADY  <= 1'b0;
            PRDATA  <= RDATA;
            PREADY  <= 1'b1;
            PSLVERR <= resp_is_err(RRESP);
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_to_axi_bridge.sv
// tb/tb_apb_to_axi_bridge.sv - directed self-checking bench for apb_to_axi_bridge
module tb_apb_to_axi_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  AWID, WID, ARID, BID = '0, RID = '0;
  logic [31:0] AWADDR, ARADDR, WDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK;
  logic        AWVALID, WVALID, ARVALID, BREADY, RREADY, WLAST;
  logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
  logic        BVALID = 1'b0, RVALID = 1'b0, RLAST = 1'b0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic [31:0] RDATA = '0;

  apb_to_axi_bridge dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AXI subordinate: memory with per-channel programmable stall cycles.
  logic [31:0] mem [logic [31:0]];
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic got_aw = 0, got_w = 0, got_ar = 0;
  logic s_awvalid = 0, s_wvalid = 0, s_arvalid = 0, s_bready = 0, s_rready = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  int n_aw = 0, n_b = 0, aw_hi = 0, w_hi = 0, overlap = 0;

  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0; RLAST = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
      end else begin
        // Handshakes completed at the posedge just past.
        if (s_awvalid && AWREADY) begin got_aw = 1; n_aw++; AWREADY = 0; end
        if (s_wvalid && WREADY) begin got_w = 1; WREADY = 0; end
        if (s_bready && BVALID) begin BVALID = 0; n_b++; got_aw = 0; got_w = 0; end
        if (s_arvalid && ARREADY) begin got_ar = 1; ARREADY = 0; end
        if (s_rready && RVALID) begin RVALID = 0; RLAST = 0; got_ar = 0; end
        if (AWVALID) aw_hi++;
        if (WVALID) w_hi++;
        if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) overlap++;
        if (AWVALID && !AWREADY && !got_aw) begin
          if (aw_cnt == aw_dly) begin AWREADY = 1; cap_awaddr = AWADDR; aw_cnt = 0; end
          else aw_cnt++;
        end
        if (WVALID && !WREADY && !got_w) begin
          if (w_cnt == w_dly) begin WREADY = 1; cap_wdata = WDATA; cap_wstrb = WSTRB; w_cnt = 0; end
          else w_cnt++;
        end
        if (got_aw && got_w && !BVALID) begin
          if (b_cnt == b_dly) begin
            mem[cap_awaddr] = cap_wdata; BVALID = 1; BRESP = bresp_cfg; b_cnt = 0;
          end else b_cnt++;
        end
        if (ARVALID && !ARREADY && !got_ar) begin
          if (ar_cnt == ar_dly) begin ARREADY = 1; cap_araddr = ARADDR; ar_cnt = 0; end
          else ar_cnt++;
        end
        if (got_ar && !RVALID) begin
          if (r_cnt == r_dly) begin
            RDATA = mem.exists(cap_araddr) ? mem[cap_araddr] : 32'h0;
            RRESP = rresp_cfg; RLAST = 1; RVALID = 1; r_cnt = 0;
          end else r_cnt++;
        end
        s_awvalid = AWVALID; s_wvalid = WVALID; s_arvalid = ARVALID;
        s_bready = BREADY; s_rready = RREADY;
      end
    end
  end

  // One APB transfer: setup at the first negedge (cycle 0); lat is the cycle
  // in which PREADY is seen. Returns during the ACK cycle.
  task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic err, output int lat);
    logic done;
    done = 0; lat = -1; rd = '0; err = 1'b1;
    @(negedge ACLK);
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    for (int c = 1; c <= 60; c++) begin
      @(negedge ACLK);
      PENABLE = 1;
      if (PREADY) begin done = 1; lat = c; rd = PRDATA; err = PSLVERR; break; end
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic apb_idle();
    @(negedge ACLK);
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          nb0;
  logic        seen;
  logic [31:0] a, d;

  initial begin
    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_ctrl", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY, PSLVERR}), 64'd0);
    check("rst_data", {PRDATA, WDATA}, 64'd0);
    check("rst_addr", 64'({AWADDR, ARADDR}), 64'd0);
    check("const_attr", 64'({AWLEN, ARLEN, AWSIZE, ARSIZE, AWBURST, ARBURST, AWLOCK, ARLOCK, WSTRB, WLAST}),
          64'({4'h0, 4'h0, 3'b010, 3'b010, 2'b01, 2'b01, 2'b00, 2'b00, 4'hF, 1'b1}));
    check("const_id", 64'({AWID, WID, ARID}), 64'd0);
    ARESETn = 1;
    apb_idle();

    // Zero-wait write then read-back
    set_dly(0, 0, 0, 0, 0);
    apb_xfer("wr104", 1, 32'h0000_0104, 32'hDEAD_BEEF, rd, err, lat);
    check("wr104_lat", 64'(lat), 64'd3);
    check("wr104_err", 64'(err), 64'd0);
    check("wr104_awaddr", 64'(cap_awaddr), 64'h104);
    check("wr104_wdata", 64'(cap_wdata), 64'hDEAD_BEEF);
    check("wr104_wstrb", 64'(cap_wstrb), 64'hF);
    apb_xfer("rd104", 0, 32'h0000_0104, 32'h0, rd, err, lat);
    check("rd104_lat", 64'(lat), 64'd3);
    check("rd104_araddr", 64'(cap_araddr), 64'h104);
    check("rd104_data", 64'(rd), 64'hDEAD_BEEF);
    check("rd104_err", 64'(err), 64'd0);

    // Back-to-back write must leave PRDATA alone; unaligned read is word-aligned
    apb_xfer("wr108", 1, 32'h0000_0108, 32'h1234_5678, rd, err, lat);
    check("wr108_prdata_hold", 64'(PRDATA), 64'hDEAD_BEEF);
    apb_xfer("rd10b", 0, 32'h0000_010B, 32'h0, rd, err, lat);
    check("rd10b_araddr", 64'(cap_araddr), 64'h108);
    check("rd10b_data", 64'(rd), 64'h1234_5678);
    apb_idle();

    // AWREADY delayed 3 cycles, WREADY immediate
    set_dly(3, 0, 0, 0, 0);
    aw_hi = 0; w_hi = 0; nb0 = n_b;
    apb_xfer("wrdly", 1, 32'h0000_0200, 32'hA5A5_0001, rd, err, lat);
    check("wrdly_aw_cycles", 64'(aw_hi), 64'd4);
    check("wrdly_w_cycles", 64'(w_hi), 64'd1);
    check("wrdly_b_count", 64'(n_b - nb0), 64'd1);
    check("wrdly_lat", 64'(lat), 64'd6);
    check("wrdly_err", 64'(err), 64'd0);
    apb_idle();

    // Error responses
    set_dly(0, 0, 0, 0, 0);
    rresp_cfg = 2'b11;
    apb_xfer("rd_decerr", 0, 32'h0000_2000, 32'h0, rd, err, lat);
    check("rd_decerr_err", 64'(err), 64'd1);
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b10;
    apb_xfer("wr_slverr", 1, 32'h0000_2004, 32'h5555_AAAA, rd, err, lat);
    check("wr_slverr_err", 64'(err), 64'd1);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b01;
    apb_xfer("rd_exokay", 0, 32'h0000_0104, 32'h0, rd, err, lat);
    check("rd_exokay_err", 64'(err), 64'd0);
    check("rd_exokay_data", 64'(rd), 64'hDEAD_BEEF);
    rresp_cfg = 2'b00;
    apb_idle();

    // Reset while waiting in RDATA
    set_dly(0, 0, 0, 0, 5);
    @(negedge ACLK);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h0000_0104;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      PENABLE = 1;
      if (RREADY) begin seen = 1; break; end
    end
    check("rst_mid_reach_rdata", 64'(seen), 64'd1);
    ARESETn = 0; PSEL = 0; PENABLE = 0;
    @(posedge ACLK); #1;
    check("rst_mid_ctrl", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY, PSLVERR}), 64'd0);
    check("rst_mid_prdata", 64'(PRDATA), 64'd0);
    check("rst_mid_addr", 64'(ARADDR), 64'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1;
    set_dly(0, 0, 0, 0, 0);
    apb_xfer("rd_after_rst", 0, 32'h0000_0104, 32'h0, rd, err, lat);
    check("rd_after_rst_data", 64'(rd), 64'hDEAD_BEEF);
    check("rd_after_rst_lat", 64'(lat), 64'd3);

    // Back-to-back alternating write/read with random stalls
    for (int i = 0; i < 4; i++) begin
      a = 32'h0000_3000 + 32'(i) * 32'd4;
      d = $urandom();
      set_dly($urandom_range(5, 0), $urandom_range(5, 0), $urandom_range(5, 0), 0, 0);
      apb_xfer("b2b_wr", 1, a, d, rd, err, lat);
      set_dly(0, 0, 0, $urandom_range(5, 0), $urandom_range(5, 0));
      apb_xfer("b2b_rd", 0, a, 32'h0, rd, err, lat);
      check("b2b_rdata", 64'(rd), 64'(d));
      check("b2b_err", 64'(err), 64'd0);
    end
    apb_idle();
    repeat (2) @(negedge ACLK);
    check("no_overlap", 64'(overlap), 64'd0);
    check("b_per_aw", 64'(n_b), 64'(n_aw));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
